// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the datapath / IR.
// The sequencer (master) reads IR fields, ALU flags and memory status,
// and drives every enable and select consumed by the datapath.
interface multicycle_control_if;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       mem_ready;

   logic       pc_write;
   logic       ir_write;
   logic       reg_w;
   logic       mem_w;
   logic       adr_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] imm_src;
   logic [1:0] reg_src;
   logic [1:0] alu_control;
   logic [3:0] flags;
   logic [3:0] state;

   modport master (
      input  cond, op, funct, rd, alu_flags, mem_ready,
      output pc_write, ir_write, reg_w, mem_w, adr_src, alu_src_a,
             alu_src_b, result_src, imm_src, reg_src, alu_control,
             flags, state
   );

   modport slave (
      output cond, op, funct, rd, alu_flags, mem_ready,
      input  pc_write, ir_write, reg_w, mem_w, adr_src, alu_src_a,
             alu_src_b, result_src, imm_src, reg_src, alu_control,
             flags, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle CPU: walks each instruction through
// 2-5 states, drives datapath enables/selects, owns the NZCV register and
// evaluates the condition field in DECODE.
module multicycle_control (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q;

   logic [3:0] cmd;
   logic       s_bit, is_cmp, rd_pc, cond_ok;
   logic [1:0] alu_dec;
   logic       pc_write_raw, ir_write_raw, reg_w_raw, mem_w_raw;

   assign cmd    = bus.funct[4:1];
   assign s_bit  = bus.funct[0];
   assign is_cmp = (cmd == 4'b1010);
   assign rd_pc  = (bus.rd == 4'd15);

   // cmd -> ALU operation; unknown commands fall back to add
   always_comb begin
      alu_dec = 2'b00;
      case (cmd)
         4'b0100: alu_dec = 2'b00;
         4'b0010: alu_dec = 2'b01;
         4'b1010: alu_dec = 2'b01;
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
         default: alu_dec = 2'b00;
      endcase
   end

   // condition field against the registered NZCV
   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags_q;
      cond_ok = 1'b1;
      case (bus.cond)
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = ~z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = ~c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = ~n;
         4'b0110: cond_ok = v;
         4'b0111: cond_ok = ~v;
         4'b1000: cond_ok = c & ~z;
         4'b1001: cond_ok = ~c | z;
         4'b1010: cond_ok = (n == v);
         4'b1011: cond_ok = (n != v);
         4'b1100: cond_ok = ~z & (n == v);
         4'b1101: cond_ok = z | (n != v);
         default: cond_ok = 1'b1;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // NZCV loads on the edge leaving EXEC* when S is set; logic ops keep C/V
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= 4'b0000;
      end else if ((state_q == EXECR || state_q == EXECI) && s_bit) begin
         flags_q[3:2] <= bus.alu_flags[3:2];
         if (!alu_dec[1]) flags_q[1:0] <= bus.alu_flags[1:0];
      end
   end

   // next state and per-state outputs
   always_comb begin
      state_d         = FETCH;
      pc_write_raw    = 1'b0;
      ir_write_raw    = 1'b0;
      reg_w_raw       = 1'b0;
      mem_w_raw       = 1'b0;
      bus.adr_src     = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b00;
      bus.result_src  = 2'b00;
      bus.imm_src     = 2'b00;
      bus.reg_src     = 2'b00;
      bus.alu_control = 2'b00;
      case (state_q)
         FETCH: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            ir_write_raw   = bus.mem_ready;
            pc_write_raw   = bus.mem_ready;
            state_d        = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            if (!cond_ok)             state_d = FETCH;
            else case (bus.op)
               2'd0:    state_d = bus.funct[5] ? EXECI : EXECR;
               2'd1:    state_d = MEMADR;
               2'd2:    state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         EXECR, EXECI: begin
            bus.alu_src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
            bus.alu_control = alu_dec;
            state_d         = ALUWB;
         end
         ALUWB: begin
            if (is_cmp)     ;
            else if (rd_pc) pc_write_raw = 1'b1;
            else            reg_w_raw    = 1'b1;
         end
         MEMADR: begin
            bus.alu_src_b = 2'b01;
            bus.imm_src   = 2'b01;
            state_d       = bus.funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.adr_src = 1'b1;
            state_d     = bus.mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.result_src = 2'b01;
            if (rd_pc) pc_write_raw = 1'b1;
            else       reg_w_raw    = 1'b1;
         end
         MEMWR: begin
            bus.adr_src = 1'b1;
            bus.reg_src = 2'b10;
            mem_w_raw   = 1'b1;
            state_d     = bus.mem_ready ? FETCH : MEMWR;
         end
         BRANCH: begin
            bus.alu_src_b  = 2'b01;
            bus.imm_src    = 2'b10;
            bus.result_src = 2'b10;
            pc_write_raw   = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // write enables are killed while reset is held so no stray write occurs
   assign bus.pc_write = pc_write_raw & ~reset;
   assign bus.ir_write = ir_write_raw & ~reset;
   assign bus.reg_w    = reg_w_raw & ~reset;
   assign bus.mem_w    = mem_w_raw & ~reset;
   assign bus.flags    = flags_q;
   assign bus.state    = state_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing controller for the multicycle build of the CPU. It runs one instruction over 2–5 cycles through a Moore FSM and drives every datapath enable and mux select. It also holds the NZCV flag register and performs conditional-execution checks. It sits between the instruction register / shared memory port and the datapath, and replaces the single-cycle decode path.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH and clears flags.
- cond  in  4  instruction[31:28], from the IR.
- op  in  2  instruction[27:26]: 0 data-processing, 1 memory, 2 branch, 3 undefined.
- funct  in  6  instruction[25:20]: [5] immediate operand, [4:1] cmd, [0] S (DP) / L (memory; 1 = load).
- rd  in  4  destination register field.
- alu_flags  in  4  combinational NZCV from the ALU.
- mem_ready  in  1  shared memory port has completed the current access.
- pc_write, ir_write, reg_w, mem_w  out  1 each  write enables.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- alu_src_a  out  1  ALU A operand: 0 = register, 1 = PC.
- alu_src_b  out  2  ALU B operand: 00 = register, 01 = extended immediate, 10 = constant 4.
- result_src  out  2  result bus: 00 = ALU output register, 01 = memory data register, 10 = ALU direct.
- imm_src, reg_src  out  2 each  same encodings as the single-cycle decoder.
- alu_control  out  2  00 add, 01 sub, 10 and, 11 or.
- flags  out  4  registered NZCV.
- state  out  4  current FSM state, for debug.

## Operation
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXECR(6), EXECI(7), ALUWB(8), BRANCH(9). Unused encodings go to FETCH.
- FETCH: adr_src=0; alu_src_a=1; alu_src_b=10; alu add; result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0. Moves to DECODE when mem_ready=1.
- DECODE: computes PC+8 (alu_src_a=1, alu_src_b=10, add). Evaluates cond against flags.
  - Cond false or op=3: go to FETCH, no writes.
  - op=0: go to EXECI if funct[5]=1, else EXECR.
  - op=1: go to MEMADR.
  - op=2: go to BRANCH.
- Condition codes:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - 1110 and 1111: always true.
- EXECR / EXECI: alu_src_a=0; alu_src_b=00 (EXECR) or 01 (EXECI); alu_control decoded from cmd. Next state ALUWB.
  - cmd decode: 0100 add, 0010 sub, 0000 and, 1100 or, 1010 cmp (sub). Any other cmd decodes as add.
  - If S=1, flags load on the edge leaving EXEC*: N and Z always; C and V only for add/sub/cmp, otherwise held.
- ALUWB: result_src=00.
  - cmd=1010 (cmp): reg_w=0, pc_write=0.
  - rd=15: pc_write=1, reg_w=0.
  - Otherwise reg_w=1.
  - Next state FETCH.
- MEMADR: alu_src_a=0; alu_src_b=01; add; imm_src=01. Next state MEMRD if L=1, else MEMWR.
- MEMRD: adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01. rd=15 gives pc_write=1; otherwise reg_w=1. Next state FETCH.
- MEMWR: adr_src=1; mem_w=1 every cycle until mem_ready=1, then FETCH. reg_src=10.
- BRANCH: alu_src_a=0 (R15=PC+8); alu_src_b=01; imm_src=10; add; result_src=10; pc_write=1. Next state FETCH.
- Every enable and select not listed for a state is 0.

## Timing
- Outputs are combinational from state (plus IR fields and mem_ready). State and flags are registered.
- Reset:
  - state=FETCH, flags=0000.
  - pc_write, ir_write, reg_w, mem_w forced 0 while reset is high, regardless of mem_ready.
  - Deasserting reset mid-instruction restarts at FETCH.
- Latency with mem_ready held at 1:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - DP (including cmp): 4 cycles.
  - B: 3 cycles.
  - Failed cond or undefined op: 2 cycles.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Flags are never written on a failed cond, a load/store, or a branch.

## Test plan
- Reset with mem_ready=1 → state=0, flags=0000, all enables 0. After release, FETCH asserts ir_write=pc_write=1 in the first cycle.
- ADD with S, cond=1110, alu_flags=0110 → states 0,1,6,8,0; flags=0110; reg_w=1 in ALUWB.
- LDR with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; reg_w only in MEMWB. Repeat with rd=15 → pc_write in MEMWB, reg_w=0.
- BEQ with Z=0 → states 0,1,0 with no writes. BEQ with Z=1 → 0,1,9,0 with pc_write=1 in BRANCH.
- CMP (cmd=1010, S=1) → alu_control=01, flags updated, reg_w=0 in ALUWB. AND with S → C and V held.
- STR with mem_ready low for 1 cycle → mem_w=1 for 2 cycles in MEMWR, then FETCH. Assert reset in MEMWR → immediate FETCH, mem_w=0.
